memory_game_ctrl: RTL

//   Game-logic stage directly upstream of the VGA card renderer for the 5x4 memory game.

---
 rtl/memory_game_ctrl.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/memory_game_ctrl.sv
// memory_game_ctrl
//   Game logic for the 5x4 memory game, feeding the VGA card renderer.
//   Debounces the three player buttons, moves a wrapping cursor over the card
//   grid and runs the flip / show / resolve sequence for each pair of picks.
//
//   Ports
//     clock_25M    in   pixel clock, all logic on its rising edge
//     reset        in   asynchronous active-high reset
//     btn_select   in   raw select button (asynchronous, active-high)
//     btn_move_x   in   raw move-column button
//     btn_move_y   in   raw move-row button
//     frame        in   one-cycle strobe at start of vertical blanking
//     card_order   in   5 bits per card, shuffled values 0..N_CARDS-1
//     card_state   out  2 bits per card: 0 hidden, 1 face-up, 2 matched
//     cursor_pos   out  selected card index, row*N_COLS + col
//     pairs_found  out  matched pair count
//     game_over    out  high while every pair is matched
//
//   state   | meaning
//   PICK1   | waiting for the first card of a pair
//   PICK2   | first card face-up, waiting for the second
//   SHOW    | both cards face-up, counting frame strobes
//   RESOLVE | one cycle: mark the pair matched or turn it back over
//   DONE    | all pairs matched, select starts a new game

module memory_game_ctrl #(
    parameter int  N_COLS          = 5,
    parameter int  N_ROWS          = 4,
    parameter int  DEBOUNCE_CYCLES = 250000,
    parameter int  SHOW_FRAMES     = 60,
    localparam int N_CARDS         = N_COLS * N_ROWS,
    localparam int N_PAIRS         = N_CARDS / 2,
    localparam int POS_W           = $clog2(N_CARDS),
    localparam int PAIR_W          = $clog2(N_PAIRS + 1)
) (
    input  logic                   clock_25M,
    input  logic                   reset,
    input  logic                   btn_select,
    input  logic                   btn_move_x,
    input  logic                   btn_move_y,
    input  logic                   frame,
    input  logic [5*N_CARDS-1:0]   card_order,
    output logic [2*N_CARDS-1:0]   card_state,
    output logic [POS_W-1:0]       cursor_pos,
    output logic [PAIR_W-1:0]      pairs_found,
    output logic                   game_over
);

    localparam int COL_W  = $clog2(N_COLS);
    localparam int ROW_W  = $clog2(N_ROWS);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SHOW_W = $clog2(SHOW_FRAMES + 1);

    localparam logic [DB_W-1:0]   DB_LOAD   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SHOW_W-1:0] SHOW_LOAD = SHOW_W'(SHOW_FRAMES - 1);

    localparam logic [1:0] CARD_HIDDEN  = 2'd0;
    localparam logic [1:0] CARD_UP      = 2'd1;
    localparam logic [1:0] CARD_MATCHED = 2'd2;

    typedef enum logic [2:0] {
        PICK1,
        PICK2,
        SHOW,
        RESOLVE,
        DONE
    } state_t;

    // ---------------- button conditioning ----------------
    // Bit 0 select, bit 1 move_x, bit 2 move_y.
    logic [2:0]      btn_raw;
    logic [2:0]      sync_a;
    logic [2:0]      sync_b;
    logic [2:0]      btn_level;
    logic [2:0]      btn_press;
    logic [DB_W-1:0] db_cnt [3];

    assign btn_raw = {btn_move_y, btn_move_x, btn_select};

    // Each counter is held at its load value while the synchronised input
    // agrees with the accepted level, and counts down while they differ;
    // reaching zero accepts the new level.
    always_ff @(posedge clock_25M or posedge reset) begin
        if (reset) begin
            sync_a    <= '0;
            sync_b    <= '0;
            btn_level <= '0;
            btn_press <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sync_a    <= btn_raw;
            sync_b    <= sync_a;
            btn_press <= '0;
            for (int i = 0; i < 3; i++) begin
                if (sync_b[i] == btn_level[i]) begin
                    db_cnt[i] <= DB_LOAD;
                end else if (db_cnt[i] == '0) begin
                    btn_level[i] <= sync_b[i];
                    btn_press[i] <= sync_b[i];
                    db_cnt[i]    <= DB_LOAD;
                end else begin
                    db_cnt[i] <= db_cnt[i] - 1'b1;
                end
            end
        end
    end

    // ---------------- cursor next value ----------------
    logic [COL_W-1:0] col, col_nxt;
    logic [ROW_W-1:0] row, row_nxt;
    logic [POS_W-1:0] pos_nxt;

    always_comb begin
        col_nxt = col;
        row_nxt = row;
        if (btn_press[1]) col_nxt = (col == COL_W'(N_COLS - 1)) ? '0 : col + 1'b1;
        if (btn_press[2]) row_nxt = (row == ROW_W'(N_ROWS - 1)) ? '0 : row + 1'b1;
        pos_nxt = POS_W'(int'(row_nxt) * N_COLS + int'(col_nxt));
    end

    // ---------------- game FSM ----------------
    state_t            state;
    logic [1:0]        cs [N_CARDS];
    logic [4:0]        order_val [N_CARDS];
    logic [POS_W-1:0]  first_pos;
    logic [POS_W-1:0]  second_pos;
    logic [SHOW_W-1:0] show_tmr;
    logic              pair_match;
    logic [PAIR_W-1:0] pairs_new;

    always_comb begin
        for (int p = 0; p < N_CARDS; p++) order_val[p] = card_order[5*p +: 5];
    end

    always_comb begin
        card_state = '0;
        for (int p = 0; p < N_CARDS; p++) card_state[2*p +: 2] = cs[p];
    end

    // Pair identity is the card value with its low bit dropped.
    assign pair_match = (order_val[first_pos] >> 1) == (order_val[second_pos] >> 1);

    always_comb begin
        pairs_new = pairs_found;
        if (pair_match && pairs_found != PAIR_W'(N_PAIRS)) pairs_new = pairs_found + 1'b1;
    end

    always_ff @(posedge clock_25M or posedge reset) begin
        if (reset) begin
            state       <= PICK1;
            col         <= '0;
            row         <= '0;
            cursor_pos  <= '0;
            pairs_found <= '0;
            game_over   <= 1'b0;
            show_tmr    <= '0;
            first_pos   <= '0;
            second_pos  <= '0;
            for (int p = 0; p < N_CARDS; p++) cs[p] <= CARD_HIDDEN;
        end else begin
            // A new game recentres the cursor; otherwise moves apply in every state.
            if (state == DONE && btn_press[0]) begin
                col        <= '0;
                row        <= '0;
                cursor_pos <= '0;
            end else begin
                col        <= col_nxt;
                row        <= row_nxt;
                cursor_pos <= pos_nxt;
            end

            // Select acts on the registered (pre-move) cursor position.
            case (state)
                PICK1: begin
                    if (btn_press[0] && cs[cursor_pos] == CARD_HIDDEN) begin
                        cs[cursor_pos] <= CARD_UP;
                        first_pos      <= cursor_pos;
                        state          <= PICK2;
                    end
                end
                PICK2: begin
                    if (btn_press[0] && cs[cursor_pos] == CARD_HIDDEN) begin
                        cs[cursor_pos] <= CARD_UP;
                        second_pos     <= cursor_pos;
                        show_tmr       <= SHOW_LOAD;
                        state          <= SHOW;
                    end
                end
                SHOW: begin
                    if (frame) begin
                        if (show_tmr == '0) state <= RESOLVE;
                        else                show_tmr <= show_tmr - 1'b1;
                    end
                end
                RESOLVE: begin
                    cs[first_pos]  <= pair_match ? CARD_MATCHED : CARD_HIDDEN;
                    cs[second_pos] <= pair_match ? CARD_MATCHED : CARD_HIDDEN;
                    pairs_found    <= pairs_new;
                    if (pairs_new == PAIR_W'(N_PAIRS)) begin
                        state     <= DONE;
                        game_over <= 1'b1;
                    end else begin
                        state <= PICK1;
                    end
                end
                DONE: begin
                    if (btn_press[0]) begin
                        for (int p = 0; p < N_CARDS; p++) cs[p] <= CARD_HIDDEN;
                        pairs_found <= '0;
                        game_over   <= 1'b0;
                        state       <= PICK1;
                    end
                end
                default: state <= PICK1;
            endcase
        end
    end

endmodule
